// File: rtl/joy_db15_resp.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : joy_db15_resp
// Purpose  : DB15 joystick responder. It presents two 16-bit button words as
//            one 32-bit active-low serial frame to an external reader that
//            drives its own shift clock and load strobe.
// Ports    : clk        - system clock (40-50 MHz), the only clock
//            reset      - asynchronous, active-high
//            JOY_CLK    - reader shift clock (async to clk)
//            JOY_LOAD   - reader load strobe, active-low (async to clk)
//            JOY_DATA   - serial data to reader, active-low, registered
//            joystick1  - player-1 buttons, active-high, clk-synchronous
//            joystick2  - player-2 buttons, active-high, clk-synchronous
//            frame_done - one-clk pulse when the 32nd bit is shifted out
//            frame_cnt  - completed frame counter, wraps at 256
//            bit_cnt    - shift edges since the last load, 0..32
// Revision : 1.0 - initial release
// ============================================================================
module joy_db15_resp (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic [5:0]  bit_cnt
);

  localparam logic [5:0] C_FRAME_BITS = 6'd32;
  localparam logic [5:0] C_LAST_BIT   = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Synchronizer and edge-detect stages
  logic r_clk_s1;
  logic r_clk_s2;
  logic r_clk_prev;
  logic r_load_s1;
  logic r_load_s2;
  logic r_load_prev;

  logic w_clk_rise;
  logic w_load_fall;
  logic w_load_req;

  // State and datapath
  state_t      r_state;
  state_t      w_state_next;
  logic        w_do_load;
  logic        w_do_shift;
  logic        w_last_bit;
  logic [31:0] r_shreg;
  logic [5:0]  r_bit_cnt;
  logic [7:0]  r_frame_cnt;
  logic        r_frame_done;
  logic        r_joy_data;

  // The load synchronizer resets high (the idle level) so that releasing
  // reset with the strobe inactive cannot look like a load edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_s1    <= 1'b0;
      r_clk_s2    <= 1'b0;
      r_clk_prev  <= 1'b0;
      r_load_s1   <= 1'b1;
      r_load_s2   <= 1'b1;
      r_load_prev <= 1'b1;
    end else begin
      r_clk_s1    <= JOY_CLK;
      r_clk_s2    <= r_clk_s1;
      r_clk_prev  <= r_clk_s2;
      r_load_s1   <= JOY_LOAD;
      r_load_s2   <= r_load_s1;
      r_load_prev <= r_load_s2;
    end
  end

  assign w_clk_rise  = r_clk_s2 & ~r_clk_prev;
  assign w_load_fall = ~r_load_s2 & r_load_prev;
  // The falling edge starts a load; the low level keeps it transparent for
  // as long as the reader holds the strobe.
  assign w_load_req  = w_load_fall | ~r_load_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A pending load overrides everything, including a simultaneous shift edge.
  always_comb begin
    w_state_next = r_state;
    w_do_load    = 1'b0;
    w_do_shift   = 1'b0;
    w_last_bit   = 1'b0;
    if (w_load_req) begin
      w_state_next = ST_LOAD;
      w_do_load    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_IDLE;
        end
        ST_LOAD: begin
          w_state_next = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_clk_rise) begin
            w_do_shift = 1'b1;
            if (r_bit_cnt == C_LAST_BIT) begin
              w_last_bit   = 1'b1;
              w_state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // Keep shifting zeros so the line idles high past the frame end.
          if (w_clk_rise) begin
            w_do_shift = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg      <= 32'd0;
      r_bit_cnt    <= 6'd0;
      r_frame_cnt  <= 8'd0;
      r_frame_done <= 1'b0;
      r_joy_data   <= 1'b1;
    end else begin
      if (w_do_load) begin
        r_shreg <= {joystick2, joystick1};
      end else if (w_do_shift) begin
        r_shreg <= {1'b0, r_shreg[31:1]};
      end

      if (w_do_load) begin
        r_bit_cnt <= 6'd0;
      end else if (w_do_shift && (r_bit_cnt != C_FRAME_BITS)) begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end

      r_frame_done <= w_last_bit;
      if (w_last_bit) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end

      r_joy_data <= ~r_shreg[0];
    end
  end

  assign JOY_DATA   = r_joy_data;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign bit_cnt    = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_resp.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_joy_db15_resp
// Purpose  : Self-checking bench for joy_db15_resp. A frame-level model holds
//            the captured 32-bit word and the number of reader clock rises;
//            the expected line level is the inverted frame bit at that index,
//            or 1 once the index runs past the frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_joy_db15_resp;

  logic        clk;
  logic        reset;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic        JOY_DATA;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic [5:0]  bit_cnt;

  joy_db15_resp dut (
    .clk        (clk),
    .reset      (reset),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .JOY_DATA   (JOY_DATA),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .bit_cnt    (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame-level reference model
  logic [31:0] m_frame;
  int          m_k;
  int          m_frames;
  int          m_done_exp;

  // Observed frame_done pulses (counted once per clk cycle high)
  int          done_seen = 0;
  logic [7:0]  fc_prev = 8'd0;
  logic [7:0]  fc_before_last = 8'd0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      done_seen++;
      fc_before_last = fc_prev;
    end
    fc_prev = frame_cnt;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_data();
    if (m_k >= 32) return 1'b1;
    return ~m_frame[m_k];
  endfunction

  function automatic logic [31:0] exp_bitcnt();
    return (m_k > 32) ? 32'd32 : 32'(m_k);
  endfunction

  task automatic check_line(input string tag);
    check({tag, "_data"}, {31'd0, JOY_DATA}, {31'd0, exp_data()});
    check({tag, "_bitcnt"}, {26'd0, bit_cnt}, exp_bitcnt());
  endtask

  task automatic do_load(input logic [15:0] j1, input logic [15:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    JOY_LOAD  = 1'b0;
    tick(3);
    JOY_LOAD  = 1'b1;
    tick(3);
    m_frame = {j2, j1};
    m_k     = 0;
    // Inputs changing after the load must not disturb the frame.
    joystick1 = 16'($urandom);
    joystick2 = 16'($urandom);
  endtask

  task automatic pulse_clk(input int hi, input int lo);
    JOY_CLK = 1'b1;
    tick(hi);
    JOY_CLK = 1'b0;
    tick(lo);
    m_k++;
    if (m_k == 32) begin
      m_frames   = (m_frames + 1) % 256;
      m_done_exp++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    m_frames = 0;
  endtask

  initial begin
    int n;
    logic start_lvl;
    logic [15:0] j1;

    reset      = 1'b1;
    JOY_CLK    = 1'b0;
    JOY_LOAD   = 1'b1;
    joystick1  = 16'd0;
    joystick2  = 16'd0;
    m_frame    = 32'd0;
    m_k        = 0;
    m_frames   = 0;
    m_done_exp = 0;
    tick(3);

    // Reset state
    check("rst_data", {31'd0, JOY_DATA}, 32'd1);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_fcnt", {24'd0, frame_cnt}, 32'd0);
    check("rst_bcnt", {26'd0, bit_cnt}, 32'd0);
    reset = 1'b0;
    tick(3);
    m_frames = 0;

    // Directed frame: only bit 0 and bit 31 pressed
    do_load(16'h0001, 16'h8000);
    check_line("basic_b0");
    for (int i = 0; i < 32; i++) begin
      pulse_clk(3, 3);
      check_line("basic");
    end
    check("basic_done", 32'(done_seen), 32'(m_done_exp));
    check("basic_fcnt", {24'd0, frame_cnt}, 32'd1);

    // Overshift: 40 rises, line idles high, counter saturates
    do_load(16'($urandom), 16'($urandom));
    check_line("over_b0");
    for (int i = 0; i < 40; i++) begin
      pulse_clk(2, 3);
      check_line("over");
    end
    check("over_done", 32'(done_seen), 32'(m_done_exp));
    check("over_fcnt", {24'd0, frame_cnt}, 32'(m_frames));

    // Random frames with random reader timing
    for (int f = 0; f < 3; f++) begin
      do_load(16'($urandom), 16'($urandom));
      check_line("rand_b0");
      n = 32 + int'($urandom_range(0, 4));
      for (int i = 0; i < n; i++) begin
        pulse_clk(int'($urandom_range(2, 4)), int'($urandom_range(2, 4)));
        check_line("rand");
      end
      check("rand_done", 32'(done_seen), 32'(m_done_exp));
      check("rand_fcnt", {24'd0, frame_cnt}, 32'(m_frames));
    end

    // Abort: reload after 10 shifts, no frame completion credited
    do_load(16'($urandom), 16'($urandom));
    for (int i = 0; i < 10; i++) pulse_clk(2, 2);
    check_line("abort_pre");
    do_load(16'($urandom), 16'($urandom));
    check_line("abort_b0");
    check("abort_done", 32'(done_seen), 32'(m_done_exp));
    check("abort_fcnt", {24'd0, frame_cnt}, 32'(m_frames));
    for (int i = 0; i < 32; i++) begin
      pulse_clk(2, 2);
      check_line("abort_new");
    end
    check("abort_done2", 32'(done_seen), 32'(m_done_exp));
    check("abort_fcnt2", {24'd0, frame_cnt}, 32'(m_frames));

    // Collision: clock rise and load fall in the same cycle
    do_load(16'($urandom), 16'($urandom));
    for (int i = 0; i < 5; i++) pulse_clk(2, 2);
    j1 = 16'($urandom);
    joystick1 = j1;
    joystick2 = 16'($urandom);
    JOY_CLK  = 1'b1;
    JOY_LOAD = 1'b0;
    tick(4);
    check("coll_bitcnt", {26'd0, bit_cnt}, 32'd0);
    check("coll_data", {31'd0, JOY_DATA}, {31'd0, ~j1[0]});
    m_frame = {joystick2, joystick1};
    m_k     = 0;
    JOY_LOAD = 1'b1;
    tick(3);
    JOY_CLK = 1'b0;
    tick(3);
    check_line("coll_post");
    for (int i = 0; i < 32; i++) pulse_clk(2, 2);
    check_line("coll_end");
    check("coll_fcnt", {24'd0, frame_cnt}, 32'(m_frames));

    // Latency: pin rise to JOY_DATA change, bit0=1, bit1=0, bit2=1
    do_load(16'h0005, 16'($urandom));
    start_lvl = JOY_DATA;
    JOY_CLK = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      n++;
      if (JOY_DATA !== start_lvl) break;
    end
    check("latency", 32'(n), 32'd4);
    JOY_CLK = 1'b0;
    tick(3);
    m_k = 1;
    pulse_clk(2, 2);
    check_line("pre_rst");

    // Reset mid-frame: line goes high without waiting for a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("arst_data", {31'd0, JOY_DATA}, 32'd1);
    check("arst_bcnt", {26'd0, bit_cnt}, 32'd0);
    check("arst_fcnt", {24'd0, frame_cnt}, 32'd0);
    tick(2);
    reset = 1'b0;
    m_frames = 0;
    tick(3);
    // Without a fresh load, reader clocks must not shift anything
    JOY_CLK = 1'b1;
    tick(3);
    JOY_CLK = 1'b0;
    tick(3);
    check("idle_bcnt", {26'd0, bit_cnt}, 32'd0);
    check("idle_data", {31'd0, JOY_DATA}, 32'd1);

    // Wrap: 256 complete frames from a cleared counter
    n = done_seen;
    for (int f = 0; f < 256; f++) begin
      do_load(16'($urandom), 16'($urandom));
      for (int i = 0; i < 32; i++) pulse_clk(2, 2);
    end
    check("wrap_fcnt", {24'd0, frame_cnt}, 32'(m_frames));
    check("wrap_zero", {24'd0, frame_cnt}, 32'd0);
    check("wrap_prev", {24'd0, fc_before_last}, 32'd255);
    check("wrap_done", 32'(done_seen - n), 32'd256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/joy_db15_resp.md
JOY_DB15_RESP -- requirements
Module: joy_db15_resp

Interface
REQ-001 clk  input  1  system clock, 40-50 MHz; the only clock in the block.
REQ-002 reset  input  1  asynchronous, active-high; forces all state to reset values.
REQ-003 JOY_CLK  input  1  serial shift clock from the DB15 reader; asynchronous to clk.
REQ-004 JOY_LOAD  input  1  parallel-load strobe from the reader; active-low; asynchronous to clk.
REQ-005 JOY_DATA  output  1  serial button data to the reader; active-low (0 = pressed); registered.
REQ-006 joystick1  input  16  player-1 buttons, active-high, clk-synchronous; layout FEDCBAUDLR at bits 9:0, L at bit 10, S at bit 11, 15:12 spare.
REQ-007 joystick2  input  16  player-2 buttons, same layout as joystick1.
REQ-008 frame_done  output  1  one-clk pulse when the 32nd bit of a frame is shifted out.
REQ-009 frame_cnt  output  8  count of completed frames.
REQ-010 bit_cnt  output  6  shift edges since the last load, 0..32.

Function
REQ-011 JOY_CLK and JOY_LOAD SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Edge detection SHALL use a third registered stage: clk_rise = sync high and previous low; load_fall = sync low and previous high.
REQ-013 Frame register SHALL be 32 bits: shreg[15:0] = joystick1, shreg[31:16] = joystick2.
REQ-014 JOY_DATA SHALL equal ~shreg[0], registered, at all times outside reset.
REQ-015 The state machine SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-016 IDLE -> LOAD when the synced load is low.
REQ-017 LOAD: shreg reloads from the inputs every clk cycle while the synced load is low, so the load is transparent; clk_rise is ignored; bit_cnt = 0. LOAD -> SHIFT when the synced load goes high.
REQ-018 SHIFT: each clk_rise shifts shreg right by one, fills bit 31 with 0 (line idles at 1), and increments bit_cnt.
REQ-019 When a clk_rise makes bit_cnt = 32, the block SHALL go SHIFT -> DONE, pulse frame_done for exactly 1 clk, and increment frame_cnt.
REQ-020 DONE: clk_rise SHALL continue to shift zeros; bit_cnt saturates at 32; JOY_DATA = 1.
REQ-021 From any state, a synced load low SHALL force LOAD on the next clk.
REQ-022 A load arriving mid-frame SHALL abort the frame with no frame_done and no frame_cnt increment.
REQ-023 If clk_rise and load-low are seen in the same cycle, load SHALL win and no shift occurs.
REQ-024 frame_cnt SHALL wrap from 255 to 0.
REQ-025 Latency: a pin edge on JOY_CLK SHALL change JOY_DATA exactly 4 clk cycles later (2 sync + 1 edge + 1 output register).
REQ-026 Changes to joystick1/2 after LOAD exits SHALL NOT affect the frame in progress.

Reset
REQ-027 On reset assertion, JOY_DATA = 1 immediately (async), frame_done = 0, frame_cnt = 0, bit_cnt = 0, shreg = 0, state = IDLE.
REQ-028 On reset, JOY_CLK synchronizer stages SHALL be 0 and JOY_LOAD synchronizer stages SHALL be 1, so no false edge is seen at release.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a fresh load.

Verification
REQ-030 Setup: joystick1 = 16'h0001, joystick2 = 16'h8000; pulse load, then 32 clocks. Required: JOY_DATA = 0 on bit 0 and bit 31, 1 elsewhere; frame_done pulses once; frame_cnt = 1.
REQ-031 Abort case: after 10 shifts, pulse load again. Required: bit_cnt returns to 0; no frame_done; frame_cnt unchanged; the new frame restarts at bit 0.
REQ-032 Collision case: JOY_CLK rise and JOY_LOAD fall within the same clk. Required: no shift; bit_cnt = 0; JOY_DATA = ~joystick1[0].
REQ-033 Overshift case: 40 clocks after load. Required: bits 32-39 read 1; bit_cnt holds at 32; a single frame_done.
REQ-034 Wrap case: run 256 complete frames. Required: frame_cnt = 0 at the end; it reads 255 just before the last frame_done.
REQ-035 Latency case: measure a single JOY_CLK pin rise to the JOY_DATA transition. Required: exactly 4 clk; with reset asserted mid-frame, JOY_DATA = 1 asynchronously.
